auth_initiator: RTL
===================

// Module: auth_initiator
// PURPOSE
//  USB Type-C authentication initiator; the requesting end paired with the responder.
//  Takes one request from policy logic: GET_DIGESTS, GET_CERTIFICATE or CHALLENGE.
//  Builds the 4-byte header, the payload and the USB control fields, then hands the message to the responder.
//  Waits for the answer under a per-type timeout, checks the answer, acknowledges it and reports done/error.
// PARAMETERS
//  PAYLOAD_W    256   request/response payload width in bits (challenge nonce = 32 bytes)
//  TO_DIGESTS   100   WAIT_RESP timeout in clk cycles for GET_DIGESTS
//  TO_CERT      200   WAIT_RESP timeout in clk cycles for GET_CERTIFICATE
//  TO_CHAL      300   WAIT_RESP timeout in clk cycles for CHALLENGE
//  MAX_RETRY    2     extra attempts after a timeout (only with AUTH_INIT_RETRY_EN)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high
//  start          in   1          request strobe; sampled only while busy=0
//  req_type       in   2          0=digests, 1=certificate, 2=challenge, 3=illegal
//  req_param1     in   8          header Param1 (slot)
//  req_param2     in   8          header Param2
//  req_nonce      in   PAYLOAD_W  challenge nonce
//  req_out        out  1          message valid to responder (level)
//  header_out     out  32         {ProtocolVersion, MessageType, Param1, Param2}
//  payload_out    out  PAYLOAD_W  request payload
//  bmRequestType  out  8          USB setup field
//  bRequest       out  8          USB setup field
//  wLength        out  16         USB setup field
//  resp_valid     in   1          responder answer valid (level, held until ack_out)
//  resp_header    in   32         answer header
//  resp_payload   in   PAYLOAD_W  answer payload
//  ack_out        out  1          one-cycle acknowledge of answer
//  busy           out  1          transaction in progress
//  done           out  1          one-cycle success pulse
//  error          out  1          one-cycle failure pulse
//  error_code     out  8          failure reason, held until next accepted start
//  rx_header      out  32         captured answer header, held until next accepted start
//  rx_payload     out  PAYLOAD_W  captured answer payload, held until next accepted start
// BEHAVIOUR
//  Reset:
//   - all outputs 0, state IDLE, timer 0, retry count 0.
//   - reset mid-transaction aborts at once; no ack_out/done/error is issued.
//  FSM: IDLE -> BUILD -> SEND -> WAIT_RESP -> CHECK -> ACK -> DONE | ERROR -> IDLE.
//  IDLE, busy=0:
//   - start with req_type 0..2 -> BUILD; clears error_code, rx_header and rx_payload.
//   - start with req_type 3 -> ERROR, code 0x01; no message is sent.
//  BUILD (1 cycle):
//   - header_out = {8'h01, 8'h81+req_type, req_param1, req_param2}.
//   - payload_out = nonce for challenge, else 0.
//   - USB fields: bmRequestType=0x00, bRequest=25.
//   - wLength = 4 for digests/certificate, 36 for challenge.
//  SEND (1 cycle): req_out<=1 -> WAIT_RESP.
//  WAIT_RESP:
//   - req_out is held at 1; timer increments each cycle from 0.
//   - resp_valid=1: capture rx_header/rx_payload, req_out<=0 -> CHECK.
//   - timer==TO_x-1 with resp_valid=0: timeout.
//   - resp_valid and timeout in the same cycle: the response wins.
//   - start is ignored while busy.
//  CHECK (1 cycle), checked in this priority order:
//   1. Version!=1 -> code 0x02.
//   2. MessageType==0x7F (responder ERROR) -> code {1'b1, Param1[6:0]}.
//   3. MessageType!=8'h01+req_type -> code 0x03.
//   4. Otherwise no error.
//  ACK: ack_out=1 for exactly 1 cycle -> DONE (no error) or ERROR.
//   - A response is always acknowledged, even when it fails the check.
//  DONE: done=1 for 1 cycle -> IDLE.
//  ERROR: error=1 for 1 cycle -> IDLE.
//  busy=1 in every state except IDLE.
//  Latency: a response on cycle N gives done on cycle N+3.
// CONFIGURATION
//  AUTH_INIT_RETRY_EN defined:
//   - on timeout with retry_cnt<MAX_RETRY: retry_cnt++, req_out<=0 for 1 cycle, then SEND again; timer restarts at 0.
//   - once retries are exhausted: ERROR, code 0x04.
//  AUTH_INIT_RETRY_EN undefined: the first timeout -> ERROR, code 0x04; no retry logic.
// TESTING
//  T1 start, type0, p1=0 -> header_out=32'h01810000, wLength=4, req_out=1.
//    resp 32'h01010000 three cycles later -> ack_out pulse, done pulse, rx_header=32'h01010000.
//  T2 type2 with nonce=0xA5.. -> wLength=36, payload_out=nonce.
//    resp 32'h01030000 -> done; a start during busy has no effect.
//  T3 type1 with no response -> error exactly TO_CERT cycles after req_out rises, code 0x04, no ack_out.
//    With retry enabled: three req_out assertions before the error.
//  T4 resp 32'h017F0300 -> ack_out, error, code 0x83.
//    resp 32'h02010000 -> code 0x02; type0 answered by 32'h01020000 -> code 0x03.
//  T5 req_type=3 -> error on the cycle after start, code 0x01, req_out stays 0.
//  T6 reset asserted in WAIT_RESP -> next cycle all outputs 0.
//    A new start then completes normally; resp_valid together with the timeout deadline -> done.

Source files
------------

// File: rtl/auth_initiator.sv
// auth_initiator: USB Type-C authentication requester; optional timeout retry under AUTH_INIT_RETRY_EN
module auth_initiator #(
    parameter int PAYLOAD_W  = 256,
    parameter int TO_DIGESTS = 100,
    parameter int TO_CERT    = 200,
    parameter int TO_CHAL    = 300
`ifdef AUTH_INIT_RETRY_EN
    ,
    parameter int MAX_RETRY  = 2
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           req_type,
    input  logic [7:0]           req_param1,
    input  logic [7:0]           req_param2,
    input  logic [PAYLOAD_W-1:0] req_nonce,
    output logic                 req_out,
    output logic [31:0]          header_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic [7:0]           bmRequestType,
    output logic [7:0]           bRequest,
    output logic [15:0]          wLength,
    input  logic                 resp_valid,
    input  logic [31:0]          resp_header,
    input  logic [PAYLOAD_W-1:0] resp_payload,
    output logic                 ack_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           error_code,
    output logic [31:0]          rx_header,
    output logic [PAYLOAD_W-1:0] rx_payload
);
    typedef enum logic [2:0] {
        S_IDLE, S_BUILD, S_SEND, S_WAIT_RESP, S_CHECK, S_ACK, S_DONE, S_ERROR
    } state_t;
    state_t      state, state_nx;
    logic [1:0]  type_q;
    logic [15:0] timer, to_lim;
    logic        expire, retry;
    logic [7:0]  chk_code;
`ifdef AUTH_INIT_RETRY_EN
    logic [7:0]  retry_cnt;
    assign retry = expire && retry_cnt < 8'(MAX_RETRY);
`else
    assign retry = 1'b0;
`endif
    assign ack_out       = state == S_ACK;
    assign done          = state == S_DONE;
    assign error         = state == S_ERROR;
    assign busy          = state != S_IDLE;
    assign bmRequestType = 8'h00;
    // Per-type deadline, and answer classification (version, then responder error, then type match)
    always_comb begin
        to_lim   = type_q == 2'd0 ? 16'(TO_DIGESTS) : type_q == 2'd1 ? 16'(TO_CERT) : 16'(TO_CHAL);
        expire   = !resp_valid && timer == to_lim - 16'd1;
        chk_code = rx_header[31:24] != 8'h01 ? 8'h02 :
                   rx_header[23:16] == 8'h7F ? {1'b1, rx_header[14:8]} :
                   rx_header[23:16] != 8'h01 + {6'd0, type_q} ? 8'h03 : 8'h00;
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end
    // Next-state logic; a response arriving on the deadline cycle beats the timeout
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start) state_nx = req_type == 2'd3 ? S_ERROR : S_BUILD;
            S_BUILD:     state_nx = S_SEND;
            S_SEND:      state_nx = S_WAIT_RESP;
            S_WAIT_RESP: state_nx = resp_valid ? S_CHECK : expire ? (retry ? S_SEND : S_ERROR) : S_WAIT_RESP;
            S_CHECK:     state_nx = S_ACK;
            S_ACK:       state_nx = error_code != 8'h00 ? S_ERROR : S_DONE;
            S_DONE:      state_nx = S_IDLE;
            S_ERROR:     state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end
    // Message build, response capture, timer and error code; request fields are latched at acceptance so later input changes cannot corrupt the message
    always_ff @(posedge clk) begin
        if (reset) begin
            req_out     <= 1'b0;
            header_out  <= '0;
            payload_out <= '0;
            bRequest    <= '0;
            wLength     <= '0;
            error_code  <= '0;
            rx_header   <= '0;
            rx_payload  <= '0;
            type_q      <= '0;
            timer       <= '0;
`ifdef AUTH_INIT_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    error_code <= req_type == 2'd3 ? 8'h01 : 8'h00;
                    if (req_type != 2'd3) begin
                        type_q      <= req_type;
                        header_out  <= {8'h01, 8'h81 + {6'd0, req_type}, req_param1, req_param2};
                        payload_out <= req_type == 2'd2 ? req_nonce : '0;
                        bRequest    <= 8'd25;
                        wLength     <= req_type == 2'd2 ? 16'd36 : 16'd4;
                        rx_header   <= '0;
                        rx_payload  <= '0;
                        timer       <= '0;
`ifdef AUTH_INIT_RETRY_EN
                        retry_cnt   <= '0;
`endif
                    end
                end
                S_SEND: req_out <= 1'b1;
                S_WAIT_RESP: begin
                    if (resp_valid) begin
                        rx_header  <= resp_header;
                        rx_payload <= resp_payload;
                        req_out    <= 1'b0;
                        timer      <= '0;
                    end else if (expire) begin
                        req_out    <= 1'b0;
                        timer      <= '0;
                        error_code <= retry ? error_code : 8'h04;
`ifdef AUTH_INIT_RETRY_EN
                        if (retry) retry_cnt <= retry_cnt + 8'd1;
`endif
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_CHECK: error_code <= chk_code;
                default: ;
            endcase
        end
    end
endmodule
